// File: rtl/sqrt_pkg.sv
// Shared definitions for the double-precision square-root core and its output wrapper.
// Holds the format sizes, the 3-bit result flag codes and the core FSM state encoding.
// Ports: none (package).
package sqrt_pkg;

  localparam int M_SIZE   = 53;    // root mantissa width incl. hidden bit
  localparam int EXP_SIZE = 11;    // biased exponent width
  localparam int BIAS     = 1023;  // exponent bias

  // Result classification codes, shared with the output wrapper
  localparam logic [2:0] FLAG_NEG    = 3'b111;
  localparam logic [2:0] FLAG_ZERO   = 3'b001;
  localparam logic [2:0] FLAG_DENORM = 3'b000;
  localparam logic [2:0] FLAG_INF    = 3'b010;
  localparam logic [2:0] FLAG_NAN    = 3'b011;
  localparam logic [2:0] FLAG_NORMAL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_classify.sv
// Combinational special-case decode of a raw IEEE-754 double into a result flag code.
// Ports: sign/exp/frac of the operand in, 3-bit flag code out (first matching rule wins).
// Latency: zero (pure combinational).
module sqrt_classify
  import sqrt_pkg::*;
(
  input  logic                sign,
  input  logic [EXP_SIZE-1:0] exp,
  input  logic [M_SIZE-2:0]   frac,
  output logic [2:0]          flags
);

  always_comb begin
    flags = FLAG_NORMAL;
    if (exp == '1 && frac != '0)      flags = FLAG_NAN;     // NaN regardless of sign
    else if (exp == '0 && frac == '0) flags = FLAG_ZERO;    // +0 and -0
    else if (exp == '0)               flags = FLAG_DENORM;  // flushed downstream
    else if (sign)                    flags = FLAG_NEG;     // includes -inf
    else if (exp == '1)               flags = FLAG_INF;
    else                              flags = FLAG_NORMAL;
  end

endmodule

// File: rtl/sqrt_core.sv
// Iterative double-precision square root: restoring digit recurrence, one root bit per cycle.
// Ports: clk/rst_n (sync active-low); in_valid/in_ready + sign/exp/frac operand;
//        out_valid/out_ready + out_mantisa (53b, hidden bit at 52), out_exp, out_flags.
// Latency: specials 1 cycle, normals 55 cycles (56 with SQRT_ROUND_NEAREST_EN: guard bit + RNE).
// Backpressure: result held stable in DONE until out_ready; one new operand only from IDLE.
module sqrt_core
  import sqrt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_SIZE-1:0] in_exp,
  input  logic [M_SIZE-2:0]   in_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M_SIZE-1:0]   out_mantisa,
  output logic [EXP_SIZE-1:0] out_exp,
  output logic [2:0]          out_flags
);

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int N_ITER = M_SIZE + 1;  // one extra guard bit
`else
  localparam int N_ITER = M_SIZE;
`endif

  state_t              state;
  logic [107:0]        rad;      // radicand, consumed two bits per cycle from the top
  logic [54:0]         rem;      // partial remainder
  logic [M_SIZE:0]     root;     // root bits, shifted in at the LSB
  logic [5:0]          cnt;
  logic [EXP_SIZE-1:0] res_exp;

  logic [2:0]          cls_flags;
  logic [EXP_SIZE:0]   exp_sum;
  logic [EXP_SIZE-1:0] exp_init;
  logic [107:0]        rad_init;
  logic [57:0]         trial;
  logic [54:0]         rem_next;
  logic [M_SIZE:0]     root_next;
  logic [M_SIZE-1:0]   fin_mant;
  logic [EXP_SIZE-1:0] fin_exp;

  sqrt_classify u_classify (
    .sign  (in_sign),
    .exp   (in_exp),
    .frac  (in_frac),
    .flags (cls_flags)
  );

  // Odd biased exponent means an even unbiased one, so 1.f is used directly;
  // otherwise the mantissa is doubled so the halved exponent stays integral.
  always_comb begin
    exp_sum  = {1'b0, in_exp} + (in_exp[0] ? (EXP_SIZE+1)'(BIAS) : (EXP_SIZE+1)'(BIAS - 1));
    exp_init = EXP_SIZE'(exp_sum >> 1);
    rad_init = in_exp[0] ? {2'b01, in_frac, 54'b0} : {1'b1, in_frac, 55'b0};
  end

  // One restoring step: try subtracting (4*root + 1) from (4*rem + next pair).
  always_comb begin
    trial     = {1'b0, rem, rad[107:106]} - {2'b00, root, 2'b01};
    rem_next  = trial[57] ? 55'({rem, rad[107:106]}) : 55'(trial);
    root_next = {root[M_SIZE-1:0], ~trial[57]};
  end

  always_comb begin
    fin_mant = root[M_SIZE-1:0];
    fin_exp  = res_exp;
`ifdef SQRT_ROUND_NEAREST_EN
    begin
      logic [M_SIZE-1:0] mant_base;
      logic              round_up;
      logic [M_SIZE:0]   mant_sum;
      mant_base = root[M_SIZE:1];
      round_up  = root[0] && ((rem != '0) || mant_base[0]);
      mant_sum  = {1'b0, mant_base} + (M_SIZE+1)'(round_up);
      if (mant_sum[M_SIZE]) begin
        // Root rounded up to exactly 2.0: renormalise to 1.0 and bump the exponent
        fin_mant = {1'b1, {(M_SIZE-1){1'b0}}};
        fin_exp  = res_exp + 1'b1;
      end else begin
        fin_mant = mant_sum[M_SIZE-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_mantisa <= '0;
      out_exp     <= '0;
      out_flags   <= '0;
      rad         <= '0;
      rem         <= '0;
      root        <= '0;
      cnt         <= '0;
      res_exp     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (cls_flags != FLAG_NORMAL) begin
              out_flags   <= cls_flags;
              out_mantisa <= '0;
              out_exp     <= '0;
              out_valid   <= 1'b1;
              state       <= ST_DONE;
            end else begin
              rad     <= rad_init;
              res_exp <= exp_init;
              rem     <= '0;
              root    <= '0;
              cnt     <= '0;
              state   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem  <= rem_next;
          root <= root_next;
          rad  <= rad << 2;
          cnt  <= cnt + 1'b1;
          if (cnt == 6'(N_ITER - 1)) state <= ST_FIN;
        end
        ST_FIN: begin
          out_mantisa <= fin_mant;
          out_exp     <= fin_exp;
          out_flags   <= FLAG_NORMAL;
          out_valid   <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_core.sv
// Testbench for sqrt_core: directed and random operands checked against an arithmetic model.
// The model derives the root as an integer square root of the scaled radicand.
module tb_sqrt_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [10:0] in_exp;
  logic [51:0] in_frac;
  logic        out_valid;
  logic        out_ready;
  logic [52:0] out_mantisa;
  logic [10:0] out_exp;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int LAT_NORM = 56;
  localparam logic [52:0] SQRT2_MANT = 53'h16A09E667F3BCD;
`else
  localparam int LAT_NORM = 55;
  localparam logic [52:0] SQRT2_MANT = 53'h16A09E667F3BCC;
`endif

  always #5 clk = ~clk;

  sqrt_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_frac     (in_frac),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mantisa (out_mantisa),
    .out_exp     (out_exp),
    .out_flags   (out_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] isqrt(input logic [127:0] x);
    logic [127:0] q, t;
    q = '0;
    for (int b = 55; b >= 0; b--) begin
      t = q | (128'd1 << b);
      if (t * t <= x) q = t;
    end
    return q;
  endfunction

  task automatic model(input logic s, input logic [10:0] e, input logic [51:0] f,
                       output logic [52:0] m, output logic [10:0] x,
                       output logic [2:0] fl, output int lat);
    logic [127:0] r, xx, q, mm;
    int ev;
    if (e == 11'h7FF && f != 0)    fl = 3'b011;
    else if (e == 0 && f == 0)     fl = 3'b001;
    else if (e == 0)               fl = 3'b000;
    else if (s)                    fl = 3'b111;
    else if (e == 11'h7FF)         fl = 3'b010;
    else                           fl = 3'b100;
    m = '0;
    x = '0;
    lat = 1;
    if (fl == 3'b100) begin
      lat = LAT_NORM;
      ev = int'(e);
      r = (128'd1 << 52) | 128'(f);
      if (ev % 2 == 0) begin
        r = r << 1;
        x = 11'((ev + 1022) / 2);
      end else begin
        x = 11'((ev + 1023) / 2);
      end
`ifdef SQRT_ROUND_NEAREST_EN
      xx = r << 54;
      q  = isqrt(xx);
      mm = q >> 1;
      if (q[0] && ((q * q != xx) || mm[0])) mm = mm + 1;
      if (mm == (128'd1 << 53)) begin
        mm = 128'd1 << 52;
        x  = x + 1;
      end
      m = mm[52:0];
`else
      xx = r << 52;
      q  = isqrt(xx);
      m  = q[52:0];
`endif
    end
  endtask

  // Present one operand, measure latency, compare result, optionally stall, then take it.
  task automatic run_op(input string tag, input logic s, input logic [10:0] e,
                        input logic [51:0] f, input int hold,
                        output logic [52:0] om, output logic [10:0] oe);
    logic [52:0] em;
    logic [10:0] ee;
    logic [2:0]  ef;
    int elat, lat;
    model(s, e, f, em, ee, ef, elat);
    @(posedge clk); #1;
    chk({tag, "_rdy_before"}, 64'(in_ready), 64'd1);
    in_sign = s; in_exp = e; in_frac = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_mant"}, 64'(out_mantisa), 64'(em));
    chk({tag, "_exp"}, 64'(out_exp), 64'(ee));
    chk({tag, "_flags"}, 64'(out_flags), 64'(ef));
    om = out_mantisa;
    oe = out_exp;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_mant"}, 64'(out_mantisa), 64'(em));
      chk({tag, "_hold_exp"}, 64'(out_exp), 64'(ee));
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_after"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
  endtask

  logic [52:0] om;
  logic [10:0] oe;
  logic [52:0] q_m[$];
  logic [10:0] q_e[$];
  logic [2:0]  q_f[$];
  logic        b_s[3];
  logic [10:0] b_e[3];
  logic [51:0] b_f[3];

  initial begin
    logic [52:0] em;
    logic [10:0] ee;
    logic [2:0]  ef;
    int elat, idx, got, sel, overlap;
    logic acc, rs;
    logic [10:0] re;
    logic [51:0] rf;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mant", 64'(out_mantisa), 64'd0);
    chk("rst_exp", 64'(out_exp), 64'd0);
    chk("rst_flags", 64'(out_flags), 64'd0);
    rst_n = 1'b1;

    // Directed values
    run_op("sqrt4", 1'b0, 11'h401, 52'h0, 0, om, oe);
    chk("sqrt4_mant_const", 64'(om), 64'(53'h1 << 52));
    chk("sqrt4_exp_const", 64'(oe), 64'h400);
    run_op("sqrt2", 1'b0, 11'h400, 52'h0, 0, om, oe);
    chk("sqrt2_mant_const", 64'(om), 64'(SQRT2_MANT));
    chk("sqrt2_exp_const", 64'(oe), 64'h3FF);
    run_op("neg1", 1'b1, 11'h3FF, 52'h0, 0, om, oe);
    run_op("pinf", 1'b0, 11'h7FF, 52'h0, 0, om, oe);
    run_op("nan", 1'b0, 11'h7FF, 52'h1, 0, om, oe);
    run_op("negzero", 1'b1, 11'h000, 52'h0, 0, om, oe);
    run_op("denorm", 1'b0, 11'h000, 52'h5, 0, om, oe);
    run_op("near4", 1'b0, 11'h400, {52{1'b1}}, 0, om, oe);
    run_op("maxexp", 1'b0, 11'h7FE, {52{1'b1}}, 0, om, oe);
    run_op("minexp", 1'b0, 11'h001, 52'h0, 0, om, oe);

    // Backpressure on sqrt(9.0)
    run_op("bp9", 1'b0, 11'h402, 52'h1 << 49, 10, om, oe);
    chk("bp9_mant_const", 64'(om), 64'(53'h18 << 48));
    chk("bp9_exp_const", 64'(oe), 64'h400);

    // Reset in the middle of an iteration
    @(posedge clk); #1;
    in_sign = 1'b0; in_exp = 11'h402; in_frac = 52'h1 << 49; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mant", 64'(out_mantisa), 64'd0);
    chk("midrst_exp", 64'(out_exp), 64'd0);
    chk("midrst_flags", 64'(out_flags), 64'd0);
    run_op("sqrt1", 1'b0, 11'h3FF, 52'h0, 0, om, oe);
    chk("sqrt1_mant_const", 64'(om), 64'(53'h1 << 52));
    chk("sqrt1_exp_const", 64'(oe), 64'h3FF);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 15);
      rs = 1'b0;
      re = 11'($urandom_range(1, 2046));
      rf = {20'($urandom), $urandom};
      case (sel)
        10: begin rs = 1'($urandom); re = 11'h000; rf = '0; end
        11: begin re = 11'h000; rf[0] = 1'b1; end
        12: begin rs = 1'b1; end
        13: begin re = 11'h7FF; rf = '0; end
        14: begin rs = 1'($urandom); re = 11'h7FF; rf[51] = 1'b1; end
        15: begin re = (sel[0]) ? 11'h7FE : 11'h001; end
        default: ;
      endcase
      run_op("rand", rs, re, rf, 0, om, oe);
    end

    // Back-to-back with in_valid held high
    b_s[0] = 1'b0; b_e[0] = 11'h401; b_f[0] = 52'h8000000000000;
    b_s[1] = 1'b1; b_e[1] = 11'h3FF; b_f[1] = 52'h0;
    b_s[2] = 1'b0; b_e[2] = 11'($urandom_range(1, 2046)); b_f[2] = {20'($urandom), $urandom};
    idx = 0; got = 0; overlap = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_sign = b_s[0]; in_exp = b_e[0]; in_frac = b_f[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 3; cyc++) begin
      acc = in_valid && in_ready;
      if (in_ready && out_valid) overlap++;
      if (out_valid) begin
        if (q_m.size() == 0) begin
          chk("b2b_unexpected_result", 64'd1, 64'd0);
        end else begin
          chk("b2b_mant", 64'(out_mantisa), 64'(q_m.pop_front()));
          chk("b2b_exp", 64'(out_exp), 64'(q_e.pop_front()));
          chk("b2b_flags", 64'(out_flags), 64'(q_f.pop_front()));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) begin
        model(b_s[idx], b_e[idx], b_f[idx], em, ee, ef, elat);
        q_m.push_back(em); q_e.push_back(ee); q_f.push_back(ef);
        idx++;
        if (idx < 3) begin
          in_sign = b_s[idx]; in_exp = b_e[idx]; in_frac = b_f[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("b2b_accepted", 64'(idx), 64'd3);
    chk("b2b_results", 64'(got), 64'd3);
    chk("b2b_leftover", 64'(q_m.size()), 64'd0);
    chk("b2b_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
